cp0_unit: RTL and testbench

- Coprocessor-0 for the P7 pipeline; sits at the M stage.
- Consumes the 5-bit ExcCode (bits [6:2]) that earlier stages attach to each instruction, together with the external hardware interrupt lines.
- Decides whether to take an exception or interrupt, and records EPC, Cause and SR.
- Serves mfc0/mtc0/eret; req tells the pipeline to flush and fetch the handler, and epc_out supplies the eret return address.

---
 rtl/cp0_unit_if.sv | 25 ++
 rtl/cp0_unit.sv | 96 +++++++++
 tb/tb_cp0_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cp0_unit_if.sv
// Pipeline <-> CP0 signal bundle for the M stage: exception info, interrupt lines,
// mtc0/mfc0/eret access and the flush request / eret return address.
interface cp0_if;
   logic [31:0] pc_M;
   logic [4:0]  exc_M;
   logic        bd_M;
   logic [5:0]  hwint;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic        eret;
   logic [31:0] rdata;
   logic [31:0] epc_out;
   logic        req;

   modport master (
      output pc_M, exc_M, bd_M, hwint, we, addr, wdata, eret,
      input  rdata, epc_out, req
   );

   modport slave (
      input  pc_M, exc_M, bd_M, hwint, we, addr, wdata, eret,
      output rdata, epc_out, req
   );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0 at the M stage: takes exceptions/interrupts, keeps SR/Cause/EPC,
// serves mfc0/mtc0/eret. req and rdata are combinational; state updates on the next edge.
module cp0_unit #(
   parameter logic [31:0] PRID = 32'h2020_1128
) (
   input  logic clk,
   input  logic reset,
   cp0_if.slave bus
);
   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;
   localparam logic [4:0] ADDR_PRID  = 5'd15;

   logic [5:0]  r_im;
   logic        r_exl;
   logic        r_ie;
   logic        r_bd;
   logic [5:0]  r_ip;
   logic [4:0]  r_exccode;
   logic [31:2] r_epc;

   logic        w_int_req;
   logic        w_exc_req;
   logic        w_req;
   logic        w_mtc0_sr;
   logic        w_mtc0_epc;
   logic [31:2] w_epc_exc;
   logic [31:0] w_rdata;
   logic [31:0] w_epc_out;

   // Nothing is taken while reset is held, even if stale state would allow it.
   assign w_int_req = (|(bus.hwint & r_im)) & r_ie & ~r_exl & ~reset;
   assign w_exc_req = (bus.exc_M != 5'd0) & ~r_exl & ~reset;
   assign w_req     = w_int_req | w_exc_req;

   assign w_mtc0_sr  = bus.we & ~w_req & (bus.addr == ADDR_SR);
   assign w_mtc0_epc = bus.we & ~w_req & (bus.addr == ADDR_EPC);

   // A delay-slot instruction restarts at its branch, one word earlier.
   assign w_epc_exc = bus.bd_M ? (bus.pc_M[31:2] - 30'd1) : bus.pc_M[31:2];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_im      <= '0;
         r_exl     <= 1'b0;
         r_ie      <= 1'b0;
         r_bd      <= 1'b0;
         r_ip      <= '0;
         r_exccode <= '0;
         r_epc     <= '0;
      end else begin
         r_ip <= bus.hwint;
         if (w_req) begin
            r_exl     <= 1'b1;
            r_exccode <= w_int_req ? 5'd0 : bus.exc_M;
            r_bd      <= bus.bd_M;
            r_epc     <= w_epc_exc;
         end else begin
            if (w_mtc0_sr) begin
               r_im  <= bus.wdata[15:10];
               r_exl <= bus.wdata[1];
               r_ie  <= bus.wdata[0];
            end else if (bus.eret) begin
               r_exl <= 1'b0;
            end
            if (w_mtc0_epc) begin
               r_epc <= bus.wdata[31:2];
            end
         end
      end
   end

   always_comb begin
      w_rdata = 32'd0;
      case (bus.addr)
         ADDR_SR:    w_rdata = {16'd0, r_im, 8'd0, r_exl, r_ie};
         ADDR_CAUSE: w_rdata = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'b00};
         ADDR_EPC:   w_rdata = {r_epc, 2'b00};
         ADDR_PRID:  w_rdata = PRID;
         default:    w_rdata = 32'd0;
      endcase
   end

   // Forward a same-cycle mtc0 EPC write so an eret issued alongside it returns correctly.
   always_comb begin
      w_epc_out = {r_epc, 2'b00};
      if (bus.we && (bus.addr == ADDR_EPC)) begin
         w_epc_out = {bus.wdata[31:2], 2'b00};
      end
   end

   assign bus.rdata   = w_rdata;
   assign bus.epc_out = w_epc_out;
   assign bus.req     = w_req;
endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: stimulus pushes expected req/rdata/epc_out per cycle into
// a queue, and a negedge monitor pops and compares them against the DUT.
module tb_cp0_unit;
   logic clk;
   logic reset;
   int   cyc;
   int   n_cmp;
   int   n_bad;

   cp0_if bus();

   cp0_unit #(.PRID(32'h2020_1128)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          cyc;
      string       name;
      logic        req;
      logic [31:0] rdata;
      logic [31:0] epc;
   } exp_t;

   exp_t exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         n_cmp = n_cmp + 3;
         if (bus.req !== e.req) begin
            n_bad = n_bad + 1;
            $display("FAIL %s req: got %0b expected %0b", e.name, bus.req, e.req);
         end
         if (bus.rdata !== e.rdata) begin
            n_bad = n_bad + 1;
            $display("FAIL %s rdata: got %08h expected %08h", e.name, bus.rdata, e.rdata);
         end
         if (bus.epc_out !== e.epc) begin
            n_bad = n_bad + 1;
            $display("FAIL %s epc_out: got %08h expected %08h", e.name, bus.epc_out, e.epc);
         end
         $display("txn %-12s cyc=%0d req=%0b rdata=%08h epc_out=%08h", e.name, cyc,
                  bus.req, bus.rdata, bus.epc_out);
      end
   end

   task automatic step(input string name, input logic rst, input logic we,
                       input logic [4:0] addr, input logic [31:0] wdata, input logic eret,
                       input logic [31:0] pc, input logic [4:0] exc, input logic bd,
                       input logic [5:0] hw, input logic x_req, input logic [31:0] x_rdata,
                       input logic [31:0] x_epc);
      exp_t e;
      reset      = rst;
      bus.we     = we;
      bus.addr   = addr;
      bus.wdata  = wdata;
      bus.eret   = eret;
      bus.pc_M   = pc;
      bus.exc_M  = exc;
      bus.bd_M   = bd;
      bus.hwint  = hw;
      e.cyc   = cyc;
      e.name  = name;
      e.req   = x_req;
      e.rdata = x_rdata;
      e.epc   = x_epc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      cyc   = 0;
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.eret = 1'b0;
      bus.pc_M = '0; bus.exc_M = '0; bus.bd_M = 1'b0; bus.hwint = '0;
      repeat (2) @(posedge clk);
      #1;
      //            name          rst we addr   wdata         er pc            exc  bd hw        req rdata         epc_out
      step("rst_sr",      0, 0, 5'd12, 32'h0,        0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_0000, 32'h0);
      step("rst_cause",   0, 0, 5'd13, 32'h0,        0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_0000, 32'h0);
      step("rst_epc",     0, 0, 5'd14, 32'h0,        0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_0000, 32'h0);
      step("mtc0_sr",     0, 1, 5'd12, 32'h0000_FC01,0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_0000, 32'h0);
      step("rd_sr",       0, 0, 5'd12, 32'h0,        0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_FC01, 32'h0);
      step("rd_prid",     0, 0, 5'd15, 32'h0,        0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h2020_1128, 32'h0);
      step("rd_other",    0, 0, 5'd7,  32'h0,        0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_0000, 32'h0);
      // hardware interrupt on hwint[2]
      step("int_take",    0, 0, 5'd13, 32'h0,        0, 32'h3010,     5'd0, 0, 6'b000100, 1, 32'h0000_0000, 32'h0);
      step("int_epc",     0, 0, 5'd14, 32'h0,        0, 32'h3010,     5'd0, 0, 6'b000100, 0, 32'h0000_3010, 32'h3010);
      step("int_cause",   0, 0, 5'd13, 32'h0,        0, 32'h3010,     5'd0, 0, 6'b000100, 0, 32'h0000_1000, 32'h3010);
      step("int_sr",      0, 0, 5'd12, 32'h0,        0, 32'h3010,     5'd0, 0, 6'b000100, 0, 32'h0000_FC03, 32'h3010);
      // clear EXL and IE, then overflow in a delay slot
      step("sr_noie",     0, 1, 5'd12, 32'h0000_FC00,0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_FC03, 32'h3010);
      step("ov_take",     0, 0, 5'd12, 32'h0,        0, 32'h3024,     5'd12,1, 6'b000000, 1, 32'h0000_FC00, 32'h3010);
      step("ov_epc",      0, 0, 5'd14, 32'h0,        0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_3020, 32'h3020);
      step("ov_cause",    0, 0, 5'd13, 32'h0,        0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h8000_0030, 32'h3020);
      // interrupt and exception together; mtc0 EPC in the same cycle is suppressed
      step("sr_ie",       0, 1, 5'd12, 32'h0000_FC01,0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_FC02, 32'h3020);
      step("both_take",   0, 1, 5'd14, 32'h5555_0000,0, 32'h3100,     5'd4, 0, 6'b000001, 1, 32'h0000_3020, 32'h5555_0000);
      step("both_epc",    0, 0, 5'd14, 32'h0,        0, 32'h0,        5'd0, 0, 6'b000001, 0, 32'h0000_3100, 32'h3100);
      step("both_cause",  0, 0, 5'd13, 32'h0,        0, 32'h0,        5'd0, 0, 6'b000001, 0, 32'h0000_0400, 32'h3100);
      // eret with a forwarded EPC write
      step("eret_fwd",    0, 1, 5'd14, 32'h0000_3047,1, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_3100, 32'h3044);
      step("eret_epc",    0, 0, 5'd14, 32'h0,        0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_3044, 32'h3044);
      step("eret_sr",     0, 0, 5'd12, 32'h0,        0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_FC01, 32'h3044);
      // syscall-like exception, then nested exception masked by EXL
      step("exc8_take",   0, 0, 5'd12, 32'h0,        0, 32'h3200,     5'd8, 0, 6'b000000, 1, 32'h0000_FC01, 32'h3044);
      step("nest_mask",   0, 0, 5'd13, 32'h0,        0, 32'h3300,     5'd10,0, 6'b000000, 0, 32'h0000_0020, 32'h3200);
      step("nest_epc",    0, 0, 5'd14, 32'h0,        0, 32'h3300,     5'd10,0, 6'b000000, 0, 32'h0000_3200, 32'h3200);
      step("cause_wr",    0, 1, 5'd13, 32'hFFFF_FFFF,0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_0020, 32'h3200);
      step("cause_ign",   0, 0, 5'd13, 32'h0,        0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_0020, 32'h3200);
      step("sr_exl",      0, 0, 5'd12, 32'h0,        0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_FC03, 32'h3200);
      // reset mid-handler
      step("rst_mid",     1, 0, 5'd15, 32'h0,        0, 32'h3400,     5'd5, 0, 6'b000001, 0, 32'h2020_1128, 32'h3200);
      step("post_sr",     0, 0, 5'd12, 32'h0,        0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_0000, 32'h0);
      step("post_cause",  0, 0, 5'd13, 32'h0,        0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_0000, 32'h0);
      step("post_epc",    0, 0, 5'd14, 32'h0,        0, 32'h0,        5'd0, 0, 6'b000000, 0, 32'h0000_0000, 32'h0);
      begin
         int budget;
         budget = 0;
         while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget = budget + 1;
         end
         if (exp_q.size() > 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
